// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - memory-stage to writeback-stage instruction handshake bundle
interface wb_stage_pipe_if #(
  parameter int P_WIDTH    = 32,
  parameter int P_PC_WIDTH = 11,
  parameter int P_REG_ADDR = 5
);
  logic                  i_valid_m;
  logic                  o_ready_m;
  logic [P_WIDTH-1:0]    i_alu_result_m;
  logic [P_PC_WIDTH-1:0] i_pc_plus_4_m;
  logic [P_WIDTH-1:0]    i_imm_m;
  logic [1:0]            i_sel_m;
  logic [2:0]            i_f3_m;
  logic [P_REG_ADDR-1:0] i_rd_m;
  logic                  i_reg_write_m;

  // Memory stage side: presents instructions, observes ready
  modport master (
    output i_valid_m, i_alu_result_m, i_pc_plus_4_m, i_imm_m, i_sel_m,
           i_f3_m, i_rd_m, i_reg_write_m,
    input  o_ready_m
  );

  // Writeback stage side: consumes instructions, drives ready
  modport slave (
    input  i_valid_m, i_alu_result_m, i_pc_plus_4_m, i_imm_m, i_sel_m,
           i_f3_m, i_rd_m, i_reg_write_m,
    output o_ready_m
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - registered RISC-V writeback stage with load wait, alignment and retire counter (option: WB_MISALIGN_TRAP_EN)
module wb_stage_pipe #(
  parameter int P_WIDTH     = 32,
  parameter int P_PC_WIDTH  = 11,
  parameter int P_REG_ADDR  = 5,
  parameter int P_CNT_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  wb_stage_pipe_if.slave         m_if,
  input  logic [P_WIDTH-1:0]     i_mem_rdata,
  input  logic                   i_mem_rvalid,
  output logic                   o_rd_we,
  output logic [P_REG_ADDR-1:0]  o_rd_addr,
  output logic [P_WIDTH-1:0]     o_rd_data,
  output logic                   o_stall,
`ifdef WB_MISALIGN_TRAP_EN
  output logic                   o_misalign,
`endif
  output logic [P_CNT_WIDTH-1:0] o_retire_cnt
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_WAIT_LD = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [P_REG_ADDR-1:0]  pend_rd_q;
  logic                   pend_we_q;
  logic [2:0]             pend_f3_q;
  logic [1:0]             pend_off_q;
  logic                   rd_we_q, rd_we_d;
  logic [P_REG_ADDR-1:0]  rd_addr_q;
  logic [P_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [P_CNT_WIDTH-1:0] cnt_q;
  logic                   misalign_q, misalign_d;

  logic                   is_wait, accept, acc_load, load_commit, commit, park;
  logic [2:0]             c_f3;
  logic [1:0]             c_off;
  logic [P_REG_ADDR-1:0]  c_rd;
  logic                   c_we;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [P_WIDTH-1:0]     aligned;

  assign is_wait        = (state_q == S_WAIT_LD);
  assign m_if.o_ready_m = ~is_wait;
  assign o_stall        = is_wait;
  assign accept         = m_if.i_valid_m & ~is_wait;
  assign acc_load       = accept & (m_if.i_sel_m == 2'b01);
  assign load_commit    = (acc_load | is_wait) & i_mem_rvalid;
  assign commit         = (accept & (m_if.i_sel_m != 2'b01)) | load_commit;
  // A load accepted without data parks its control fields until rvalid
  assign park           = acc_load & ~i_mem_rvalid;

  // While waiting, the commit context comes from the parked load, not the bus
  assign c_f3  = is_wait ? pend_f3_q  : m_if.i_f3_m;
  assign c_off = is_wait ? pend_off_q : m_if.i_alu_result_m[1:0];
  assign c_rd  = is_wait ? pend_rd_q  : m_if.i_rd_m;
  assign c_we  = is_wait ? pend_we_q  : m_if.i_reg_write_m;

  // Pick the addressed byte/halfword out of the word-aligned read data and extend it
  always_comb begin
    ld_byte = i_mem_rdata[7:0];
    case (c_off)
      2'd1:    ld_byte = i_mem_rdata[15:8];
      2'd2:    ld_byte = i_mem_rdata[23:16];
      2'd3:    ld_byte = i_mem_rdata[31:24];
      default: ld_byte = i_mem_rdata[7:0];
    endcase
    ld_half = c_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (c_f3)
      3'b000:  aligned = {{(P_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  aligned = {{(P_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  aligned = {{(P_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  aligned = {{(P_WIDTH-16){1'b0}}, ld_half};
      default: aligned = i_mem_rdata;
    endcase
  end

  // Result mux, misalignment detect and next-state decode for the commit registers
  always_comb begin
    rd_data_d = m_if.i_alu_result_m;
    if (load_commit) begin
      rd_data_d = aligned;
    end else begin
      case (m_if.i_sel_m)
        2'b10:   rd_data_d = {{(P_WIDTH-P_PC_WIDTH){1'b0}}, m_if.i_pc_plus_4_m};
        2'b11:   rd_data_d = m_if.i_imm_m;
        default: rd_data_d = m_if.i_alu_result_m;
      endcase
    end
`ifdef WB_MISALIGN_TRAP_EN
    misalign_d = load_commit &
                 ((((c_f3 == 3'b001) || (c_f3 == 3'b101)) && c_off[0]) ||
                  ((c_f3 == 3'b010) && (c_off != 2'b00)));
`else
    misalign_d = 1'b0;
`endif
    rd_we_d = commit & c_we & (c_rd != '0) & ~misalign_d;
    state_d = state_q;
    if (park)
      state_d = S_WAIT_LD;
    else if (is_wait && i_mem_rvalid)
      state_d = S_IDLE;
  end

  // FSM, parked load context, commit outputs and retire counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pend_rd_q  <= '0;
      pend_we_q  <= 1'b0;
      pend_f3_q  <= '0;
      pend_off_q <= '0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_we_q    <= rd_we_d;
      misalign_q <= misalign_d;
      if (park) begin
        pend_rd_q  <= m_if.i_rd_m;
        pend_we_q  <= m_if.i_reg_write_m;
        pend_f3_q  <= m_if.i_f3_m;
        pend_off_q <= m_if.i_alu_result_m[1:0];
      end
      if (rd_we_d) begin
        rd_addr_q <= c_rd;
        rd_data_q <= rd_data_d;
      end
      if (commit)
        cnt_q <= cnt_q + {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_rd_we      = rd_we_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_data    = rd_data_q;
  assign o_retire_cnt = cnt_q;
`ifdef WB_MISALIGN_TRAP_EN
  assign o_misalign   = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - scoreboard bench for wb_stage_pipe
module tb_wb_stage_pipe;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } wr_t;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rvalid;
  logic        o_rd_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_stall;
  logic [31:0] o_retire_cnt;
`ifdef WB_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int  vec_cnt = 0;
  int  err_cnt = 0;
  wr_t exp_q[$];

  wb_stage_pipe_if #(.P_WIDTH(32), .P_PC_WIDTH(11), .P_REG_ADDR(5)) m_if ();

  wb_stage_pipe #(.P_WIDTH(32), .P_PC_WIDTH(11), .P_REG_ADDR(5), .P_CNT_WIDTH(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .m_if         (m_if.slave),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_rvalid (i_mem_rvalid),
    .o_rd_we      (o_rd_we),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_stall      (o_stall),
`ifdef WB_MISALIGN_TRAP_EN
    .o_misalign   (o_misalign),
`endif
    .o_retire_cnt (o_retire_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] cnt);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Present one instruction for one accept edge; call at posedge+1
  task automatic issue(input logic [1:0] sel, input logic [31:0] alu, input logic [10:0] pc,
                       input logic [31:0] imm, input logic [2:0] f3, input logic [4:0] rd,
                       input logic we, input logic rv, input logic [31:0] rdata);
    m_if.i_sel_m          = sel;
    m_if.i_alu_result_m   = alu;
    m_if.i_pc_plus_4_m    = pc;
    m_if.i_imm_m          = imm;
    m_if.i_f3_m           = f3;
    m_if.i_rd_m           = rd;
    m_if.i_reg_write_m    = we;
    m_if.i_valid_m        = 1'b1;
    i_mem_rvalid          = rv;
    i_mem_rdata           = rdata;
    chk("ready_at_issue", {31'd0, m_if.o_ready_m}, 32'd1);
    @(posedge i_clk);
    #1;
    m_if.i_valid_m = 1'b0;
    i_mem_rvalid   = 1'b0;
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge i_clk) begin
    if (i_rst_n && o_rd_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we_addr", {27'd0, o_rd_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, o_rd_addr}, {27'd0, e.addr});
        chk("wr_data", o_rd_data, e.data);
        chk("wr_cnt", o_retire_cnt, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    m_if.i_valid_m = 1'b0; m_if.i_sel_m = 2'b00; m_if.i_alu_result_m = '0;
    m_if.i_pc_plus_4_m = '0; m_if.i_imm_m = '0; m_if.i_f3_m = '0;
    m_if.i_rd_m = '0; m_if.i_reg_write_m = 1'b0;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    #12;
    chk("rst_we",   {31'd0, o_rd_we}, 32'd0);
    chk("rst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("rst_data", o_rd_data, 32'd0);
    chk("rst_cnt",  o_retire_cnt, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", {31'd0, m_if.o_ready_m}, 32'd1);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    @(posedge i_clk); #1;

    // ALU result, latency 1
    exp_wr(5'd5, 32'h0000_1234, 32'd1);
    issue(2'b00, 32'h0000_1234, 11'h0, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 32'h0);

    // Same-cycle loads: LB off2 and LBU off2
    exp_wr(5'd6, 32'hFFFF_FFFF, 32'd2);
    issue(2'b01, 32'h0100_0002, 11'h0, 32'h0, 3'b000, 5'd6, 1'b1, 1'b1, 32'h80FF_7F01);
    exp_wr(5'd7, 32'h0000_00FF, 32'd3);
    issue(2'b01, 32'h0100_0002, 11'h0, 32'h0, 3'b100, 5'd7, 1'b1, 1'b1, 32'h80FF_7F01);

    // LHU off2 with data three cycles late, valid held upstream
    exp_wr(5'd8, 32'h0000_BEEF, 32'd4);
    issue(2'b01, 32'h0200_0006, 11'h0, 32'h0, 3'b101, 5'd8, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      m_if.i_valid_m = 1'b1;
      if (i == 2) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBEEF_0000;
      end
      @(negedge i_clk);
      chk("wait_stall", {31'd0, o_stall}, 32'd1);
      chk("wait_ready", {31'd0, m_if.o_ready_m}, 32'd0);
      @(posedge i_clk); #1;
    end
    m_if.i_valid_m = 1'b0;
    i_mem_rvalid   = 1'b0;
    @(negedge i_clk);
    chk("post_wait_ready", {31'd0, m_if.o_ready_m}, 32'd1);
    @(posedge i_clk); #1;

    // Stray rvalid with no load in flight
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h5555_5555;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;

    // Back-to-back PC+4 / immediate results
    exp_wr(5'd9,  32'h0000_07FC, 32'd5);
    issue(2'b10, 32'h55, 11'h7FC, 32'hABCD_E000, 3'b000, 5'd9,  1'b1, 1'b0, 32'h0);
    exp_wr(5'd10, 32'hABCD_E000, 32'd6);
    issue(2'b11, 32'h55, 11'h7FC, 32'hABCD_E000, 3'b000, 5'd10, 1'b1, 1'b0, 32'h0);
    exp_wr(5'd11, 32'h0000_07FC, 32'd7);
    issue(2'b10, 32'h55, 11'h7FC, 32'hABCD_E000, 3'b000, 5'd11, 1'b1, 1'b0, 32'h0);
    exp_wr(5'd12, 32'hABCD_E000, 32'd8);
    issue(2'b11, 32'h55, 11'h7FC, 32'hABCD_E000, 3'b000, 5'd12, 1'b1, 1'b0, 32'h0);

    // LH sign-extend at off0, LW full word
    exp_wr(5'd13, 32'hFFFF_8001, 32'd9);
    issue(2'b01, 32'h0300_0000, 11'h0, 32'h0, 3'b001, 5'd13, 1'b1, 1'b1, 32'h1234_8001);
    exp_wr(5'd14, 32'hDEAD_BEEF, 32'd10);
    issue(2'b01, 32'h0300_0004, 11'h0, 32'h0, 3'b010, 5'd14, 1'b1, 1'b1, 32'hDEAD_BEEF);

    // rd=0 commits without a write but still retires
    issue(2'b00, 32'h0000_0099, 11'h0, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0, 32'h0);
    @(negedge i_clk);
    chk("rd0_cnt", o_retire_cnt, 32'd11);
    chk("rd0_we", {31'd0, o_rd_we}, 32'd0);
    @(posedge i_clk); #1;

    // Reset during WAIT_LD drops the pending load
    issue(2'b01, 32'h0400_0000, 11'h0, 32'h0, 3'b010, 5'd15, 1'b1, 1'b0, 32'h0);
    @(negedge i_clk);
    chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt",  o_retire_cnt, 32'd0);
    chk("mid_rst_we",   {31'd0, o_rd_we}, 32'd0);
    chk("mid_rst_addr", {27'd0, o_rd_addr}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("post_rst_ready", {31'd0, m_if.o_ready_m}, 32'd1);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h7777_7777;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    @(negedge i_clk);
    chk("post_rst_cnt", o_retire_cnt, 32'd0);
    @(posedge i_clk); #1;

    // Misaligned LW at off1
`ifdef WB_MISALIGN_TRAP_EN
    issue(2'b01, 32'h0500_0001, 11'h0, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1, 32'h1122_3344);
    @(negedge i_clk);
    chk("mis_flag", {31'd0, o_misalign}, 32'd1);
    chk("mis_we",   {31'd0, o_rd_we}, 32'd0);
    chk("mis_cnt",  o_retire_cnt, 32'd1);
`else
    exp_wr(5'd3, 32'h1122_3344, 32'd1);
    issue(2'b01, 32'h0500_0001, 11'h0, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1, 32'h1122_3344);
    @(negedge i_clk);
    chk("mis_cnt", o_retire_cnt, 32'd1);
`endif

    repeat (3) @(negedge i_clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
